// File: rtl/id_hazard_controller_pkg.sv
// Shared types for the decode-stage hazard controller.
//   Contents: register address type, EX/MEM destination bundle, FSM state encoding,
//   and the register-match helper (r0 is hard-wired zero, so it never aliases).
package id_hazard_controller_pkg;

  localparam int REG_ADDR_LEN = 5;
  localparam int HZ_STATE_LEN = 2;

  typedef logic [REG_ADDR_LEN-1:0] reg_addr_t;

  // Destination information carried by an instruction in EX or MEM.
  typedef struct packed {
    reg_addr_t dest;
    logic      wb_en;
    logic      mem_read;
  } stage_dst_t;

  typedef enum logic [HZ_STATE_LEN-1:0] {
    HZ_RUN   = 2'd0,
    HZ_STALL = 2'd1,
    HZ_FLUSH = 2'd2
  } hz_state_e;

  function automatic logic reg_match(reg_addr_t src, reg_addr_t dst);
    return (src != '0) && (src == dst);
  endfunction

endpackage

// File: rtl/id_hazard_controller_if.sv
// Signal bundle between the ID/EX/MEM pipeline and the hazard controller.
//   master: pipeline side, drives decode/EX/MEM info, receives stall/flush controls.
//   slave:  hazard controller side.
interface id_hazard_controller_if #(
  parameter int CNT_W = 16
);
  import id_hazard_controller_pkg::*;

  logic             forward_en;
  reg_addr_t        id_src1;
  reg_addr_t        id_src2;
  logic             id_uses_src2;
  logic [1:0]       id_branch_cmd;
  logic             branch_taken;
  stage_dst_t       ex;
  stage_dst_t       mem;

  logic             hazard_detected;
  logic             pc_freeze;
  logic             ifid_freeze;
  logic             ifid_flush;
  logic             stall_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output forward_en, id_src1, id_src2, id_uses_src2, id_branch_cmd, branch_taken, ex, mem,
    input  hazard_detected, pc_freeze, ifid_freeze, ifid_flush, stall_timeout,
           stall_cycles, flush_count
  );

  modport slave (
    input  forward_en, id_src1, id_src2, id_uses_src2, id_branch_cmd, branch_taken, ex, mem,
    output hazard_detected, pc_freeze, ifid_freeze, ifid_flush, stall_timeout,
           stall_cycles, flush_count
  );

endinterface

// File: rtl/id_hazard_detect.sv
// Combinational RAW-hazard compare of ID sources against EX/MEM destinations.
//   Latency: zero (pure combinational).
//   Ports: forwarding mode, ID sources, branch command, EX/MEM destination bundles -> raw.
module id_hazard_detect
  import id_hazard_controller_pkg::*;
(
  input  logic       forward_en,
  input  reg_addr_t  src1,
  input  reg_addr_t  src2,
  input  logic       uses_src2,
  input  logic [1:0] branch_cmd,
  input  stage_dst_t ex,
  input  stage_dst_t mem,
  output logic       raw
);

  // With forwarding, only a load in EX stalls ordinary ops. Branches resolve in
  // ID and see no forwarded values, so they also wait on any EX writer and on a
  // load still in MEM.
  function automatic logic src_raw(reg_addr_t s, logic fe, logic br,
                                   stage_dst_t e, stage_dst_t m);
    logic ex_hit;
    logic mem_hit;
    ex_hit  = reg_match(s, e.dest);
    mem_hit = reg_match(s, m.dest);
    if (!fe)
      return (ex_hit && e.wb_en) || (mem_hit && m.wb_en);
    return (ex_hit && e.mem_read) || (br && ex_hit && e.wb_en) || (br && mem_hit && m.mem_read);
  endfunction

  logic is_branch;

  assign is_branch = (branch_cmd != 2'b00);
  assign raw = src_raw(src1, forward_en, is_branch, ex, mem)
             | (uses_src2 & src_raw(src2, forward_en, is_branch, ex, mem));

endmodule

// File: rtl/id_hazard_controller.sv
// Decode-stage sequencer: RAW stalls, taken-branch flushes, perf counters, stall watchdog.
//   Latency: stall/flush controls are Mealy, same cycle as the hazard; counters update next edge.
//   Ports: clk, rst (async, active high), hz (slave side of id_hazard_controller_if).
module id_hazard_controller
  import id_hazard_controller_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,   // 1..7
  parameter int STALL_LIMIT  = 16,  // 2..255
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  id_hazard_controller_if.slave hz
);

  localparam logic [2:0] FCNT_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] SCNT_LAST = 8'(STALL_LIMIT - 1);

  hz_state_e        state, state_n;
  logic [2:0]       fcnt, fcnt_n;
  logic [7:0]       scnt;
  logic             timeout_q;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  logic raw;
  logic stall_hold;
  logic flush_start;

  id_hazard_detect u_detect (
    .forward_en (hz.forward_en),
    .src1       (hz.id_src1),
    .src2       (hz.id_src2),
    .uses_src2  (hz.id_uses_src2),
    .branch_cmd (hz.id_branch_cmd),
    .ex         (hz.ex),
    .mem        (hz.mem),
    .raw        (raw)
  );

  // A stall outranks a taken branch: the branch re-resolves once operands are ready.
  // While flushing, the instruction in ID is being discarded, so hazards are moot.
  assign stall_hold  = raw && (state != HZ_FLUSH);
  assign flush_start = hz.branch_taken && !raw && (state != HZ_FLUSH);

  always_comb begin
    state_n = state;
    fcnt_n  = fcnt;
    unique case (state)
      HZ_RUN, HZ_STALL: begin
        if (raw) begin
          state_n = HZ_STALL;
        end else if (hz.branch_taken) begin
          state_n = HZ_FLUSH;
          fcnt_n  = FCNT_INIT;
        end else begin
          state_n = HZ_RUN;
        end
      end
      HZ_FLUSH: begin
        if (fcnt == 3'd0) state_n = HZ_RUN;
        else              fcnt_n  = fcnt - 3'd1;
      end
      default: begin
        state_n = HZ_RUN;
        fcnt_n  = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= HZ_RUN;
      fcnt  <= 3'd0;
    end else begin
      state <= state_n;
      fcnt  <= fcnt_n;
    end
  end

  // Watchdog: scnt tracks consecutive effective stall cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scnt      <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      if (stall_hold) begin
        if (scnt != 8'hFF) scnt <= scnt + 8'd1;
        if (scnt == SCNT_LAST) timeout_q <= 1'b1;
      end else begin
        scnt <= 8'd0;
      end
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_hold && (stall_cnt != '1))  stall_cnt <= stall_cnt + 1'b1;
      if (flush_start && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign hz.hazard_detected = stall_hold;
  assign hz.pc_freeze       = stall_hold;
  assign hz.ifid_freeze     = stall_hold;
  assign hz.ifid_flush      = flush_start || (state == HZ_FLUSH);
  assign hz.stall_timeout   = timeout_q;
  assign hz.stall_cycles    = stall_cnt;
  assign hz.flush_count     = flush_cnt;

endmodule
